// File: rtl/fullchip_psum_merger_pkg.sv
// Shared widths, helpers and defaults for the fullchip psum merger.
package fullchip_psum_merger_pkg;

    localparam int unsigned DefCol    = 8;
    localparam int unsigned DefBwPsum = 20;
    localparam int unsigned DefNCore  = 2;
    localparam int unsigned DefDepth  = 4;
    localparam int unsigned DefTagW   = 8;

    typedef enum logic {
        SumSigned = 1'b0,
        SumAbs    = 1'b1
    } sum_mode_e;

    // Ceiling log2, with clog2_f(1) = 0.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of one core's lane sum; the extra bit covers the +2^(bw-1) magnitude.
    function automatic int unsigned sum_w(input int unsigned col, input int unsigned bw);
        return bw + clog2_f(col) + 1;
    endfunction

    // Width of the chip-wide lane sum.
    function automatic int unsigned tot_w(input int unsigned col, input int unsigned bw,
                                          input int unsigned n);
        return sum_w(col, bw) + clog2_f(n);
    endfunction

    // Bit offset of a core row within the packed bus.
    function automatic int unsigned row_lsb(input int unsigned core, input int unsigned col,
                                            input int unsigned bw);
        return core * col * bw;
    endfunction

    // Bit offset of lane j of core k within the packed bus.
    function automatic int unsigned lane_lsb(input int unsigned core, input int unsigned lane,
                                             input int unsigned col, input int unsigned bw);
        return (core * col + lane) * bw;
    endfunction

endpackage

// File: rtl/fullchip_psum_merger_psum_row_fifo.sv
// Per-core row FIFO: wrap-bit pointers, head read combinationally from storage.
module psum_row_fifo
    import fullchip_psum_merger_pkg::*;
#(
    parameter int unsigned width = 160,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en,
    output logic [width-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (depth > 1) ? clog2_f(depth) : 1;
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [width-1:0] mem_q [depth];
    logic             do_wr, do_rd;

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Guard against misuse even though the top already gates both strobes.
    assign do_wr = wr_en && !full && reset && !flush;
    assign do_rd = rd_en && !empty;

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
        if (do_rd) rd_ptr_d = rd_ptr_q + PtrOne;
    end

    // Pointer registers; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Row storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fullchip_psum_merger.sv
// Merges one psum row per core into an output beat with a chip-wide lane sum.
module fullchip_psum_merger
    import fullchip_psum_merger_pkg::*;
#(
    parameter int unsigned col     = DefCol,
    parameter int unsigned bw_psum = DefBwPsum,
    parameter int unsigned n_core  = DefNCore,
    parameter int unsigned depth   = DefDepth,
    parameter int unsigned tag_w   = DefTagW
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flush,
    input  logic                                   abs_mode,
    input  logic [n_core-1:0]                      in_valid,
    input  logic [n_core*col*bw_psum-1:0]          in_data,
    output logic [n_core-1:0]                      in_ready,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [n_core*col*bw_psum-1:0]          out_data,
    output logic [tot_w(col, bw_psum, n_core)-1:0] out_sum,
    output logic [tag_w-1:0]                       out_tag,
    output logic [n_core-1:0]                      err_ovf
);

    localparam int unsigned RW = col * bw_psum;
    localparam int unsigned TW = tot_w(col, bw_psum, n_core);
    localparam logic [bw_psum-1:0] LaneZero = '0;
    localparam logic [tag_w-1:0]   TagOne   = tag_w'(1);

    logic [n_core-1:0]    fifo_full, fifo_empty, wr_en;
    logic [n_core*RW-1:0] heads;
    logic                 merge;

    logic                 out_valid_q, out_valid_d;
    logic [n_core*RW-1:0] out_data_q, out_data_d;
    logic [TW-1:0]        out_sum_q, out_sum_d;
    logic [tag_w-1:0]     out_tag_q, out_tag_d;
    logic [tag_w-1:0]     tag_cnt_q, tag_cnt_d;
    logic [n_core-1:0]    err_q, err_d;

    logic [TW-1:0]        lane_sum;
    logic [bw_psum-1:0]   lane, mag;
    logic [TW-1:0]        term;

    // Ready depends only on registered FIFO state, never on a same-cycle pop.
    assign in_ready = ~fifo_full;
    assign wr_en    = in_valid & ~fifo_full;
    assign merge    = (&(~fifo_empty)) && (!out_valid_q || out_ready);

    for (genvar k = 0; k < n_core; k++) begin : g_fifo
        psum_row_fifo #(
            .width (RW),
            .depth (depth)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .wr_en   (wr_en[k]),
            .wr_data (in_data[row_lsb(k, col, bw_psum) +: RW]),
            .rd_en   (merge),
            .rd_data (heads[row_lsb(k, col, bw_psum) +: RW]),
            .full    (fifo_full[k]),
            .empty   (fifo_empty[k])
        );
    end

    // Lane-sum tree over every head lane, signed or by magnitude.
    always_comb begin
        lane_sum = '0;
        lane     = '0;
        mag      = '0;
        term     = '0;
        for (int unsigned i = 0; i < n_core * col; i++) begin
            lane = heads[i*bw_psum +: bw_psum];
            if (sum_mode_e'(abs_mode) == SumAbs) begin
                // Unsigned negate maps -2^(bw-1) onto +2^(bw-1) exactly.
                mag  = lane[bw_psum-1] ? (LaneZero - lane) : lane;
                term = {{(TW - bw_psum){1'b0}}, mag};
            end else begin
                term = {{(TW - bw_psum){lane[bw_psum-1]}}, lane};
            end
            lane_sum = lane_sum + term;
        end
    end

    // Output register, tag counter and sticky overflow next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sum_d   = out_sum_q;
        out_tag_d   = out_tag_q;
        tag_cnt_d   = tag_cnt_q;
        err_d       = err_q | (in_valid & fifo_full);
        if (merge) begin
            out_valid_d = 1'b1;
            out_data_d  = heads;
            out_sum_d   = lane_sum;
            out_tag_d   = tag_cnt_q;
            tag_cnt_d   = tag_cnt_q + TagOne;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State update; flush clears everything except the sticky errors.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sum_q   <= '0;
            out_tag_q   <= '0;
            tag_cnt_q   <= '0;
            err_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sum_q   <= '0;
            out_tag_q   <= '0;
            tag_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sum_q   <= out_sum_d;
            out_tag_q   <= out_tag_d;
            tag_cnt_q   <= tag_cnt_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sum   = out_sum_q;
    assign out_tag   = out_tag_q;
    assign err_ovf   = err_q;

endmodule

// File: tb/tb_fullchip_psum_merger.sv
// Scoreboard bench for fullchip_psum_merger with directed vectors.
module tb_fullchip_psum_merger;

    localparam int unsigned COL = 8;
    localparam int unsigned BW  = 20;
    localparam int unsigned NC  = 2;
    localparam int unsigned RW  = COL * BW;
    localparam int unsigned DW  = NC * RW;
    localparam int unsigned TW  = 25;
    localparam int unsigned TGW = 8;

    typedef struct {
        logic [DW-1:0]  data;
        logic [TW-1:0]  sum;
        logic [TGW-1:0] tag;
    } beat_t;

    logic           clk = 1'b0;
    logic           reset, flush, abs_mode, out_ready;
    logic [NC-1:0]  in_valid, in_ready, err_ovf;
    logic [DW-1:0]  in_data, out_data;
    logic           out_valid;
    logic [TW-1:0]  out_sum;
    logic [TGW-1:0] out_tag;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    fullchip_psum_merger #(
        .col     (COL),
        .bw_psum (BW),
        .n_core  (NC),
        .depth   (4),
        .tag_w   (TGW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .abs_mode  (abs_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sum   (out_sum),
        .out_tag   (out_tag),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] row_of(input int v);
        logic [RW-1:0] r;
        logic [BW-1:0] l;
        l = v[BW-1:0];
        for (int j = 0; j < COL; j++) r[j*BW +: BW] = l;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic v0, input int d0, input logic v1, input int d1);
        in_valid = {v1, v0};
        in_data  = {row_of(d1), row_of(d0)};
        tick();
        in_valid = '0;
    endtask

    task automatic push(input int d0, input int d1, input logic [TW-1:0] s,
                        input logic [TGW-1:0] t);
        beat_t b;
        b.data = {row_of(d1), row_of(d0)};
        b.sum  = s;
        b.tag  = t;
        exp_q.push_back(b);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got tag %0d expected no beat", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (out_data !== e.data) begin
                        bad++;
                        $display("FAIL beat_data tag%0d: got %h expected %h", e.tag, out_data,
                                 e.data);
                    end
                    check("beat_sum", 64'(out_sum), 64'(e.sum));
                    check("beat_tag", 64'(out_tag), 64'(e.tag));
                end
            end
        end
    end

    initial begin
        #200000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        reset = 1'b0; flush = 1'b0; abs_mode = 1'b0; out_ready = 1'b0;
        in_valid = '0; in_data = '0;

        // Reset with random traffic.
        repeat (3) begin
            in_valid  = NC'($urandom());
            for (int w = 0; w < DW / 32; w++) in_data[w*32 +: 32] = $urandom();
            out_ready = 1'($urandom());
            abs_mode  = 1'($urandom());
            tick();
        end
        in_valid = '0; out_ready = 1'b1; abs_mode = 1'b0; reset = 1'b1;
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_err_ovf", 64'(err_ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd3);
        check("rst_out_data_zero", 64'(out_data == '0), 64'd1);

        // Basic merge: +1 / -2 lanes; abs then signed.
        abs_mode = 1'b1;
        push(1, -2, 25'd24, 8'd0);
        write(1'b1, 1, 1'b1, -2);
        check("lat_not_yet", 64'(out_valid), 64'd0);
        tick();
        check("lat_valid", 64'(out_valid), 64'd1);
        abs_mode = 1'b0;
        push(1, -2, 25'h1FFFFF8, 8'd1);
        write(1'b1, 1, 1'b1, -2);
        drain(10);

        // Skew: core1 silent stalls everything.
        do_flush();
        write(1'b1, 3, 1'b0, 0);
        write(1'b1, 4, 1'b0, 0);
        write(1'b1, 5, 1'b0, 0);
        tick();
        check("skew_no_valid", 64'(out_valid), 64'd0);
        check("skew_in_ready", 64'(in_ready), 64'd3);
        push(3, 7, 25'd80, 8'd0);
        write(1'b0, 0, 1'b1, 7);
        drain(10);
        repeat (3) tick();
        check("skew_one_beat", 64'(out_valid), 64'd0);

        // Backpressure: 1 in output register, 4 in each FIFO.
        do_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(10 + i, 20 + i, TW'(240 + 16 * i), TGW'(i));
            write(1'b1, 10 + i, 1'b1, 20 + i);
        end
        tick();
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_valid_held", 64'(out_valid), 64'd1);
        check("bp_tag_held", 64'(out_tag), 64'd0);
        check("bp_sum_held", 64'(out_sum), 64'd240);
        write(1'b0, 0, 1'b1, 99);
        check("bp_err_ovf", 64'(err_ovf), 64'd2);
        out_ready = 1'b1;
        drain(20);

        // Extreme lanes: -2^19 everywhere.
        do_flush();
        abs_mode = 1'b1;
        push(-524288, -524288, 25'h0800000, 8'd0);
        write(1'b1, -524288, 1'b1, -524288);
        tick();
        abs_mode = 1'b0;
        push(-524288, -524288, 25'h1800000, 8'd1);
        write(1'b1, -524288, 1'b1, -524288);
        drain(10);

        // Flush mid-stream with a sticky core0 overflow.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        out_ready = 1'b0;
        write(1'b1, 1, 1'b1, 1);
        write(1'b1, 2, 1'b1, 2);
        write(1'b1, 3, 1'b1, 3);
        write(1'b1, 4, 1'b0, 0);
        write(1'b1, 5, 1'b0, 0);
        write(1'b1, 6, 1'b0, 0);
        check("fl_err_set", 64'(err_ovf), 64'd1);
        check("fl_pending", 64'(out_valid), 64'd1);
        do_flush();
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd3);
        check("fl_err_kept", 64'(err_ovf), 64'd1);
        check("fl_tag", 64'(out_tag), 64'd0);
        out_ready = 1'b1;
        push(8, 9, 25'd136, 8'd0);
        write(1'b1, 8, 1'b1, 9);
        drain(10);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
